// File: rtl/pixel_status_master_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pixel_status_master_pkg
// Description : Shared FSM state encoding and PIO slave register map for the
//               pixel status master.
// Revision    : 1.0 - initial release
// ============================================================================
package pixel_status_master_pkg;

  // Master sequencing states; width is fixed so the encoding is stable.
  typedef enum logic [2:0] {
    INIT     = 3'd0,
    IDLE     = 3'd1,
    RD_EDGE  = 3'd2,
    CAP_EDGE = 3'd3,
    RD_LVL   = 3'd4,
    CAP_LVL  = 3'd5,
    CLR      = 3'd6,
    PUSH     = 3'd7
  } state_t;

  // PIO slave register select values.
  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  // True for the states that drive exactly one bus access.
  function automatic logic is_bus_state(input state_t s);
    return (s == INIT) || (s == RD_EDGE) || (s == RD_LVL) || (s == CLR);
  endfunction

endpackage : pixel_status_master_pkg
`default_nettype wire

// File: rtl/pixel_status_poll_timer.sv
`default_nettype none
// ============================================================================
// Module      : pixel_status_poll_timer
// Description : Idle-cycle counter that pulses expire on the cycle it reaches
//               POLL_CYCLES-1 while enabled, then wraps to zero. A value of
//               zero for POLL_CYCLES never expires.
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_status_poll_timer #(
  parameter int POLL_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic expire
);

  localparam int c_CNT_W = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST =
    c_CNT_W'((POLL_CYCLES == 0) ? 0 : (POLL_CYCLES - 1));
  localparam logic c_ACTIVE = (POLL_CYCLES != 0);

  logic [c_CNT_W-1:0] r_count;
  logic               w_at_last;

  assign w_at_last = (r_count == c_LAST);
  assign expire    = c_ACTIVE && enable && w_at_last;

  // Count idle cycles; clear has priority so a new poll always restarts at 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable) begin
      if (w_at_last) begin
        r_count <= '0;
      end else begin
        r_count <= r_count + 1'b1;
      end
    end
  end

endmodule : pixel_status_poll_timer
`default_nettype wire

// File: rtl/pixel_status_master.sv
`default_nettype none
// ============================================================================
// Module      : pixel_status_master
// Description : Avalon-MM master servicing a PIO slave. Programs the irq
//               mask after reset, then on irq or a periodic poll reads the
//               edge-capture register, reads the level register when edges
//               are present, clears edge-capture and hands the pair to a
//               valid/ready consumer.
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_status_master
  import pixel_status_master_pkg::*;
#(
  parameter int               WIDTH       = 4,
  parameter int               POLL_CYCLES = 1024,
  parameter logic [WIDTH-1:0] MASK_INIT   = WIDTH'(4'hF)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             irq,
  output logic [1:0]       avm_address,
  output logic             avm_chipselect,
  output logic             avm_write_n,
  output logic [31:0]      avm_writedata,
  input  logic [31:0]      avm_readdata,
  output logic             status_valid,
  input  logic             status_ready,
  output logic [WIDTH-1:0] status_edges,
  output logic [WIDTH-1:0] status_level
);

  state_t           r_state;
  state_t           w_next_state;
  // Registered copy of reset: keeps INIT quiet while reset is held, so the
  // mask write happens only in the first cycle after release.
  logic             r_reset_q;
  logic [WIDTH-1:0] r_edge;
  logic [WIDTH-1:0] r_level;
  logic [WIDTH-1:0] w_rd_bits;
  logic             w_poll_enable;
  logic             w_poll_clear;
  logic             w_poll_expire;

  assign w_rd_bits     = avm_readdata[WIDTH-1:0];
  assign w_poll_enable = (r_state == IDLE);
  assign w_poll_clear  = (r_state == IDLE) && (w_next_state == RD_EDGE);
  assign status_edges  = r_edge;
  assign status_level  = r_level;

  // Readdata bits above WIDTH carry nothing for this block.
  generate
    if (WIDTH < 32) begin : g_rdata_unused
      logic w_unused_rdata_hi;
      assign w_unused_rdata_hi = ^avm_readdata[31:WIDTH];
    end
  endgenerate

  pixel_status_poll_timer #(
    .POLL_CYCLES (POLL_CYCLES)
  ) u_poll_timer (
    .clk    (clk),
    .reset  (reset),
    .enable (w_poll_enable),
    .clear  (w_poll_clear),
    .expire (w_poll_expire)
  );

  // State register; reset parks in INIT and aborts any transaction.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= INIT;
      r_reset_q <= 1'b1;
    end else begin
      r_state   <= w_next_state;
      r_reset_q <= 1'b0;
    end
  end

  // Next-state sequencing; irq and poll expiry share the single RD_EDGE entry.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      INIT:     if (!r_reset_q) w_next_state = IDLE;
      IDLE:     if (irq || w_poll_expire) w_next_state = RD_EDGE;
      RD_EDGE:  w_next_state = CAP_EDGE;
      CAP_EDGE: w_next_state = (w_rd_bits == '0) ? IDLE : RD_LVL;
      RD_LVL:   w_next_state = CAP_LVL;
      CAP_LVL:  w_next_state = CLR;
      CLR:      w_next_state = PUSH;
      PUSH:     if (status_ready) w_next_state = IDLE;
      default:  w_next_state = INIT;
    endcase
  end

  // Bus and handshake outputs decoded from the current state.
  always_comb begin
    avm_chipselect = 1'b0;
    avm_write_n    = 1'b1;
    avm_address    = ADDR_DATA;
    avm_writedata  = '0;
    status_valid   = 1'b0;
    case (r_state)
      INIT: begin
        if (!r_reset_q) begin
          avm_chipselect = 1'b1;
          avm_write_n    = 1'b0;
          avm_address    = ADDR_MASK;
          avm_writedata  = 32'(MASK_INIT);
        end
      end
      RD_EDGE: begin
        avm_chipselect = 1'b1;
        avm_address    = ADDR_EDGE;
      end
      RD_LVL: begin
        avm_chipselect = 1'b1;
        avm_address    = ADDR_DATA;
      end
      CLR: begin
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        avm_address    = ADDR_EDGE;
      end
      PUSH: begin
        status_valid = 1'b1;
      end
      default: begin
        status_valid = 1'b0;
      end
    endcase
  end

  // Capture read data one cycle after each read strobe; held through PUSH.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_edge  <= '0;
      r_level <= '0;
    end else begin
      if (r_state == CAP_EDGE) r_edge  <= w_rd_bits;
      if (r_state == CAP_LVL)  r_level <= w_rd_bits;
    end
  end

endmodule : pixel_status_master
`default_nettype wire
